// File: rtl/comparator_16bit_d.sv
// Purpose : registered magnitude comparator producing one-hot greater/less/equal flags.
// Latency : 2 clocks (nibble compare, then MSB-first priority merge); one result per clock.
// Backpr. : none; in_valid bubbles flow through as out_valid=0 while the flags hold.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears every pipeline register
//   in_valid   a/b qualify this cycle
//   a, b       WIDTH-bit operands (WIDTH a multiple of 4, 4..64)
//   out_valid  greater/less/equal carry a new result this cycle
//   greater    a > b
//   less       a < b
//   equal      a == b
//
// Build option: define COMPARATOR_SIGNED_EN to compare the operands as two's complement.
module comparator_16bit_d #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic             greater,
  output logic             less,
  output logic             equal
);

  localparam int NIB = WIDTH / 4;

  // Stage-1 pipeline word: per-nibble gt/lt vectors plus the qualifier.
  typedef struct packed {
    logic           vld;
    logic [NIB-1:0] gt;
    logic [NIB-1:0] lt;
  } s1_t;

  logic [WIDTH-1:0] a_cmp;
  logic [WIDTH-1:0] b_cmp;
  logic [NIB-1:0]   gt_nib;
  logic [NIB-1:0]   lt_nib;
  s1_t              s1_q;
  logic             dec_gt;
  logic             dec_lt;

  // Operand conditioning ahead of the nibble compare.
  always_comb begin
    a_cmp = a;
    b_cmp = b;
`ifdef COMPARATOR_SIGNED_EN
    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so only the top nibble needs touching; lower nibbles stay unsigned.
    a_cmp[WIDTH-1] = ~a[WIDTH-1];
    b_cmp[WIDTH-1] = ~b[WIDTH-1];
`else
    a_cmp[WIDTH-1] = a[WIDTH-1];
    b_cmp[WIDTH-1] = b[WIDTH-1];
`endif
  end

  // Stage 1: independent 4-bit compares per nibble.
  always_comb begin
    gt_nib = '0;
    lt_nib = '0;
    for (int i = 0; i < NIB; i++) begin
      gt_nib[i] = a_cmp[4*i +: 4] > b_cmp[4*i +: 4];
      lt_nib[i] = a_cmp[4*i +: 4] < b_cmp[4*i +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
    end else begin
      s1_q.vld <= in_valid;
      s1_q.gt  <= gt_nib;
      s1_q.lt  <= lt_nib;
    end
  end

  // Stage 2: priority merge. Scanning upward and letting each differing
  // nibble overwrite the decision leaves the most significant one in charge.
  always_comb begin
    dec_gt = 1'b0;
    dec_lt = 1'b0;
    for (int i = 0; i < NIB; i++) begin
      if (s1_q.gt[i]) begin
        dec_gt = 1'b1;
        dec_lt = 1'b0;
      end else if (s1_q.lt[i]) begin
        dec_gt = 1'b0;
        dec_lt = 1'b1;
      end
    end
  end

  // Output registers; flags only load on a valid slot so they hold through bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      greater   <= 1'b0;
      less      <= 1'b0;
      equal     <= 1'b0;
    end else begin
      out_valid <= s1_q.vld;
      if (s1_q.vld) begin
        greater <= dec_gt;
        less    <= dec_lt;
        equal   <= ~(dec_gt | dec_lt);
      end
    end
  end

endmodule

// File: tb/tb_comparator_16bit_d.sv
// Purpose : scoreboard bench for comparator_16bit_d with directed hand-computed vectors.
// Latency : expects each result exactly 2 clocks after the input is sampled.
// Backpr. : none; bubbles checked for out_valid=0 with held flags.
module tb_comparator_16bit_d;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        greater;
  logic        less;
  logic        equal;

  comparator_16bit_d #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .greater   (greater),
    .less      (less),
    .equal     (equal)
  );

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] LT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  typedef struct {
    logic [2:0] exp;
    int         due;
    string      name;
  } sb_t;

  sb_t        sb[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic [2:0] last_flags = 3'b000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops on every out_valid, checks held flags on bubbles,
  // checks cleared outputs while reset is asserted.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      n_cmp++;
      if ({out_valid, greater, less, equal} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state: got %b, want 0000", {out_valid, greater, less, equal});
      end
      last_flags = 3'b000;
    end else if (out_valid === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out_valid at cycle %0d: flags %b", cyc, {greater, less, equal});
      end else begin
        e = sb.pop_front();
        if ({greater, less, equal} !== e.exp || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s: got flags %b at cycle %0d, want %b at cycle %0d",
                   e.name, {greater, less, equal}, cyc, e.exp, e.due);
        end
      end
      last_flags = {greater, less, equal};
    end else begin
      n_cmp++;
      if (out_valid !== 1'b0 || {greater, less, equal} !== last_flags) begin
        n_fail++;
        $display("FAIL bubble_hold at cycle %0d: got ov=%b flags %b, want ov=0 flags %b",
                 cyc, out_valid, {greater, less, equal}, last_flags);
      end
    end
  end

  task automatic issue(input logic [15:0] va, input logic [15:0] vb,
                       input logic [2:0] exp, input string name);
    sb_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    e.exp    = exp;
    e.due    = cyc + 2;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic bubble(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [2:0] exp_sc;
    logic [2:0] exp_neg;
    int         waited;
`ifdef COMPARATOR_SIGNED_EN
    exp_sc  = LT;   // 8000 (-32768) < 7FFF
    exp_neg = LT;   // FFFF (-1) < 0001
`else
    exp_sc  = GT;
    exp_neg = GT;
`endif
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bubble(3);

    issue(16'h0000, 16'h0000, EQ, "zero_eq");
    bubble(2);
    issue(16'hF81A, 16'hC28F, GT, "f81a_gt");
    issue(16'hAA9C, 16'hD7A0, LT, "aa9c_lt");
    issue(16'h7C98, 16'h7C28, GT, "nib1_gt");
    bubble(1);
    issue(16'h8000, 16'h7FFF, exp_sc, "sign_corner");
    issue(16'hFFFF, 16'hFFFF, EQ, "ones_eq");
    issue(16'h1230, 16'h1231, LT, "lsb_nib_lt");
    issue(16'h5F00, 16'h6000, LT, "msb_wins_lt");
    bubble(3);

    // Four back-to-back then a bubble; flags must hold through it.
    issue(16'h0001, 16'h0000, GT, "b2b_0");
    issue(16'h1234, 16'h1234, EQ, "b2b_1");
    issue(16'hFFFF, 16'h0001, exp_neg, "b2b_2");
    issue(16'h0F00, 16'h0E0F, GT, "b2b_3");
    bubble(4);

    // Reset with two comparisons in flight while a result is on the outputs.
    issue(16'h4000, 16'h3FFF, GT, "pre_rst_0");
    issue(16'h0000, 16'h0001, LT, "pre_rst_1");
    issue(16'h2222, 16'h2222, EQ, "pre_rst_2");
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    n_cmp++;
    if ({out_valid, greater, less, equal} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_clear: got %b, want 0000", {out_valid, greater, less, equal});
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bubble(4);
    issue(16'h00A0, 16'h00B0, LT, "post_rst_lt");
    bubble(1);

    waited = 0;
    while (sb.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    bubble(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
